serial_adder: RTL and testbench

- Bit-serial N-bit adder built around one 1-bit full adder cell plus a registered carry.
- Operands and carry-in are captured on start and processed LSB-first, one bit per clock.
- The result is presented with a done pulse.
- It is the next lab stage after the combinational adder cells: it consumes the cell's sum/carry outputs every cycle and turns them into a multi-bit result.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/FullAdder.sv | 21 ++
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ============================================================================
// Module  : serial_adder_pkg
// Purpose : Shared FSM encoding and default width for the bit-serial adder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

`default_nettype wire

// File: rtl/FullAdder.sv
// ============================================================================
// Module  : FullAdder
// Purpose : 1-bit full adder cell (sum and carry-out of three input bits).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module FullAdder (
  input  logic FA_A,
  input  logic FA_B,
  input  logic Cin,
  output logic FA_S,
  output logic Cout
);

  assign FA_S = FA_A ^ FA_B ^ Cin;
  assign Cout = (FA_A & FA_B) | (FA_A & Cin) | (FA_B & Cin);

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module  : serial_adder
// Purpose : Bit-serial WIDTH-bit adder, LSB first, one bit per clock,
//           built around a single FullAdder cell and a registered carry.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  sa_state_e        r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic w_fa_s;
  logic w_fa_cout;

  FullAdder u_fa (
    .FA_A (r_a_sr[0]),
    .FA_B (r_b_sr[0]),
    .Cin  (r_carry),
    .FA_S (w_fa_s),
    .Cout (w_fa_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ADD: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          r_sum_sr <= {w_fa_s, r_sum_sr[WIDTH-1:1]};
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= w_fa_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_cout  <= w_fa_cout;
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls to IDLE.
          r_done <= 1'b0;
          if (start) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_sum_sr <= '0;
            r_cout   <= 1'b0;
            r_state  <= ADD;
            r_busy   <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum_sr;
  assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module  : tb_serial_adder
// Purpose : Directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=2).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks busy/done through all 8 ADD cycles, leaving the bench in the done cycle.
  task automatic add_phase8(input string tag);
    for (int k = 1; k <= 8; k++) begin
      chk({tag, "_busy"}, {31'd0, busy8}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done8}, 32'd0);
      step();
    end
  endtask

  task automatic check_done8(input string tag, input logic [7:0] es, input logic ec);
    chk({tag, "_done"}, {31'd0, done8}, 32'd1);
    chk({tag, "_idlebusy"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_sum"}, {24'd0, sum8}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, ec});
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [7:0] es, input logic ec);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    step();
    start8 = 1'b0;
    add_phase8(tag);
    check_done8(tag, es, ec);
  endtask

  initial begin
    logic [4:0] n5;
    logic [2:0] exp3;

    // Reset held for two cycles
    step(); step();
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum",  {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    reset = 1'b0;
    step();

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    step();
    run8("ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    step();

    // Back-to-back: next start asserted during the done cycle
    run8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    add_phase8("b2b");
    check_done8("b2b", 8'h7E, 1'b0);
    step();
    chk("b2b_after_done", {31'd0, done8}, 32'd0);
    chk("b2b_after_busy", {31'd0, busy8}, 32'd0);
    chk("b2b_hold_sum", {24'd0, sum8}, 32'h7E);

    // Start during ADD is ignored; operand changes have no effect
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 3) begin
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
      end
      chk("ign_busy", {31'd0, busy8}, 32'd1);
      chk("ign_nodone", {31'd0, done8}, 32'd0);
      step();
      start8 = 1'b0;
      if (k == 4) begin
        a8 = 8'h55; b8 = 8'hAA;
      end
    end
    check_done8("ign", 8'h46, 1'b0);
    step();

    // Reset during ADD aborts with no done pulse
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_done", {31'd0, done8}, 32'd0);
    chk("abort_sum",  {24'd0, sum8}, 32'd0);
    chk("abort_cout", {31'd0, cout8}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      chk("abort_nodone", {31'd0, done8}, 32'd0);
      step();
    end
    run8("fresh", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);
    step();

    // WIDTH=2 exhaustive, back-to-back so each done follows its start by 3 cycles
    for (int n = 0; n < 32; n++) begin
      n5 = n[4:0];
      a2 = n5[4:3]; b2 = n5[2:1]; cin2 = n5[0];
      exp3 = {1'b0, n5[4:3]} + {1'b0, n5[2:1]} + {2'b0, n5[0]};
      start2 = 1'b1;
      step();
      start2 = 1'b0;
      chk("w2_busy1", {31'd0, busy2}, 32'd1);
      chk("w2_nodone1", {31'd0, done2}, 32'd0);
      step();
      chk("w2_busy2", {31'd0, busy2}, 32'd1);
      chk("w2_nodone2", {31'd0, done2}, 32'd0);
      step();
      chk("w2_done", {31'd0, done2}, 32'd1);
      chk("w2_result", {29'd0, cout2, sum2}, {29'd0, exp3});
    end
    step();
    chk("w2_final_idle", {31'd0, done2 | busy2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
